// File: rtl/pipelined_shifter.sv
// Pipelined log2 barrel shifter: left, logical-right or arithmetic-right, with sticky-out flag.
// Latency: P = ceil($clog2(W)/SPR) cycles from acceptance to out_valid when never stalled.
// Backpressure: one global advance (out_ready || !out_valid) stalls every stage; in_ready = advance.
module pipelined_shifter #(
    parameter int M                   = 23,
    parameter int E                   = 8,
    parameter int extra_bits_mantissa = 7,
    parameter int SPR                 = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [M+extra_bits_mantissa-1:0] number_input,
    input  logic [E:0]                       shift_amount,
    input  logic                             right_shift,
    input  logic                             arithmetic_shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [M+extra_bits_mantissa-1:0] number_output,
    output logic                             sticky
);

    localparam int W = M + extra_bits_mantissa;
    localparam int L = $clog2(W);
    localparam int P = (L + SPR - 1) / SPR;
    localparam logic [E:0]   W_AMT = (E + 1)'(W);
    localparam logic [W-1:0] ONES  = {W{1'b1}};

    // Everything a stage needs travels together: partial result, running sticky and control.
    typedef struct packed {
        logic [W-1:0] dat;
        logic         stk;
        logic [L-1:0] amt;
        logic         dir;    // 1: right
        logic         arith;  // arithmetic right only
        logic         sign;
        logic         sat;
    } stage_t;

    stage_t         st_q [P];
    stage_t         st_d [P];
    logic [P-1:0]   vld_q;
    logic           advance;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Each stage applies its slice of barrel levels to the previous register; the last stage saturates.
    always_comb begin
        stage_t cur;
        for (int s = 0; s < P; s++) begin
            if (s == 0) begin
                cur.dat   = number_input;
                cur.stk   = 1'b0;
                cur.amt   = shift_amount[L-1:0];
                cur.dir   = right_shift;
                cur.arith = right_shift && arithmetic_shift;
                cur.sign  = number_input[W-1];
                cur.sat   = (shift_amount >= W_AMT);
            end else begin
                cur = st_q[s-1];
            end
            for (int k = 0; k < L; k++) begin
                if ((k / SPR) == s && cur.amt[k]) begin
                    if (cur.dir) begin
                        cur.stk = cur.stk | (|(cur.dat & ~(ONES << (1 << k))));
                        cur.dat = (cur.dat >> (1 << k)) |
                                  ((cur.arith && cur.sign) ? ~(ONES >> (1 << k)) : '0);
                    end else begin
                        cur.stk = cur.stk | (|(cur.dat & ~(ONES >> (1 << k))));
                        cur.dat = cur.dat << (1 << k);
                    end
                end
            end
            // Every input bit is either shifted out or still present, so sticky|data covers |input.
            if (s == P - 1 && cur.sat) begin
                cur.stk = cur.stk | (|cur.dat);
                cur.dat = (cur.arith && cur.sign) ? ONES : '0;
            end
            st_d[s] = cur;
        end
    end

    // Pipeline registers: all stages move together on advance, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < P; s++) st_q[s] <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int s = 1; s < P; s++) vld_q[s] <= vld_q[s-1];
            for (int s = 0; s < P; s++) st_q[s] <= st_d[s];
        end
    end

    assign out_valid     = vld_q[P-1];
    assign number_output = st_q[P-1].dat;
    assign sticky        = st_q[P-1].stk;

endmodule
